// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - FIFO controller over a 2-port SRAM macro with a 2-entry output buffer
// Optional SRAM_FIFO_BYPASS_EN: enqueues into an empty FIFO skip the SRAM and land in the output buffer.
module sram_fifo_ctrl #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 128,
  parameter int ADDR_BITS = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic [WIDTH-1:0]     enq_data,
  output logic                 deq_valid,
  input  logic                 deq_ready,
  output logic [WIDTH-1:0]     deq_data,
  output logic [ADDR_BITS:0]   count,
  output logic [ADDR_BITS-1:0] sram_a1,
  output logic                 sram_csb1,
  output logic                 sram_web1,
  output logic                 sram_oeb1,
  output logic [WIDTH-1:0]     sram_i1,
  output logic [ADDR_BITS-1:0] sram_a2,
  output logic                 sram_csb2,
  output logic                 sram_oeb2,
  output logic                 sram_web2,
  input  logic [WIDTH-1:0]     sram_o2
);

  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS+1)'(DEPTH);

  logic [ADDR_BITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_BITS:0]   mem_cnt_q, mem_cnt_d;
  logic                 rd_inflight_q, rd_inflight_d;
  logic [1:0]           ob_cnt_q, ob_cnt_d;
  logic [WIDTH-1:0]     ob0_q, ob0_d, ob1_q, ob1_d;

  logic             wr_fire, deq_fire, rd_issue, bypass, sram_wr, push;
  logic [2:0]       ob_after;
  logic [WIDTH-1:0] push_data;

  assign enq_ready = (mem_cnt_q != FULL_CNT);
  assign deq_valid = (ob_cnt_q != 2'd0);
  assign deq_data  = ob0_q;
  assign count     = mem_cnt_q + (ADDR_BITS+1)'(rd_inflight_q) + (ADDR_BITS+1)'(ob_cnt_q);

  assign wr_fire  = enq_valid && enq_ready && !reset;
  assign deq_fire = deq_valid && deq_ready;
  // Output-buffer occupancy once this cycle's pop and the pending capture settle
  assign ob_after = {1'b0, ob_cnt_q} + {2'b0, rd_inflight_q} - {2'b0, deq_fire};
  assign rd_issue = !reset && (mem_cnt_q != '0) && (ob_after < 3'd2);

`ifdef SRAM_FIFO_BYPASS_EN
  assign bypass = wr_fire && (mem_cnt_q == '0) && !rd_inflight_q &&
                  (({1'b0, ob_cnt_q} - {2'b0, deq_fire}) < 3'd2);
`else
  assign bypass = 1'b0;
`endif

  assign sram_wr   = wr_fire && !bypass;
  assign push      = rd_inflight_q || bypass;
  assign push_data = rd_inflight_q ? sram_o2 : enq_data;

  assign sram_a1   = wptr_q;
  assign sram_csb1 = !sram_wr;
  assign sram_web1 = !sram_wr;
  assign sram_oeb1 = 1'b1;
  assign sram_i1   = enq_data;
  assign sram_a2   = rptr_q;
  assign sram_csb2 = !rd_issue;
  assign sram_oeb2 = !rd_issue;
  assign sram_web2 = 1'b1;

  always_comb begin
    wptr_d        = wptr_q + ADDR_BITS'(sram_wr);
    rptr_d        = rptr_q + ADDR_BITS'(rd_issue);
    mem_cnt_d     = mem_cnt_q + (ADDR_BITS+1)'(sram_wr) - (ADDR_BITS+1)'(rd_issue);
    rd_inflight_d = rd_issue;
    ob0_d         = ob0_q;
    ob1_d         = ob1_q;
    ob_cnt_d      = ob_cnt_q;
    case ({push, deq_fire})
      2'b10: begin
        if (ob_cnt_q == 2'd0) ob0_d = push_data;
        else                  ob1_d = push_data;
        ob_cnt_d = ob_cnt_q + 2'd1;
      end
      2'b01: begin
        ob0_d    = ob1_q;
        ob_cnt_d = ob_cnt_q - 2'd1;
      end
      2'b11: begin
        if (ob_cnt_q == 2'd1) begin
          ob0_d = push_data;
        end else begin
          ob0_d = ob1_q;
          ob1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      ob_cnt_q      <= 2'd0;
      ob0_q         <= '0;
      ob1_q         <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      ob_cnt_q      <= ob_cnt_d;
      ob0_q         <= ob0_d;
      ob1_q         <= ob1_d;
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - directed bench for sram_fifo_ctrl with a behavioural SRAM2RW macro
module tb_sram_fifo_ctrl;

`ifdef SRAM_FIFO_BYPASS_EN
  localparam int   LAT = 1;
  localparam logic BYP = 1'b1;
`else
  localparam int   LAT = 3;
  localparam logic BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        enq_valid, enq_ready, deq_valid, deq_ready;
  logic [15:0] enq_data, deq_data;
  logic [7:0]  count;
  logic [6:0]  sram_a1, sram_a2;
  logic        sram_csb1, sram_web1, sram_oeb1, sram_csb2, sram_oeb2, sram_web2;
  logic [15:0] sram_i1, sram_o2;
  logic [15:0] mem [128];

  always #5 clock = ~clock;

  sram_fifo_ctrl dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .count(count),
    .sram_a1(sram_a1), .sram_csb1(sram_csb1), .sram_web1(sram_web1),
    .sram_oeb1(sram_oeb1), .sram_i1(sram_i1),
    .sram_a2(sram_a2), .sram_csb2(sram_csb2), .sram_oeb2(sram_oeb2),
    .sram_web2(sram_web2), .sram_o2(sram_o2)
  );

  // Macro model: write on port 1, registered read on port 2
  always @(posedge clock) begin
    if (!sram_csb1 && !sram_web1) mem[sram_a1] <= sram_i1;
    if (!sram_csb2 && !sram_oeb2) sram_o2 <= mem[sram_a2];
  end

  int          passed = 0, total = 0, fails = 0, deq_n = 0;
  logic [15:0] q [$];
  logic        obs_dv, obs_er;
  logic [15:0] obs_dd, last_deq;
  logic [7:0]  obs_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ev, input logic [15:0] ed, input logic dr);
    logic [15:0] exp;
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    @(negedge clock);
    obs_dv  = deq_valid;
    obs_dd  = deq_data;
    obs_er  = enq_ready;
    obs_cnt = count;
    check("count_vs_model", count, q.size());
    if (deq_valid && deq_ready) begin
      exp = 'x;
      if (q.size() > 0) exp = q.pop_front();
      check("deq_order", deq_data, exp);
      last_deq = deq_data;
      deq_n++;
    end
    if (ev && enq_ready) q.push_back(ed);
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 400) begin
      cyc(1'b0, 16'h0, 1'b1);
      n++;
    end
    check("drain_done", q.size(), 0);
    cyc(1'b0, 16'h0, 1'b1);
    check("drained_deq_valid", obs_dv, 1'b0);
  endtask

  initial begin
    reset = 1'b0; enq_valid = 1'b1; enq_data = 16'hBEEF; deq_ready = 1'b0;
    #1 reset = 1'b1;
    @(negedge clock);
    check("rst_csb1", sram_csb1, 1'b1);
    check("rst_web1", sram_web1, 1'b1);
    check("rst_csb2", sram_csb2, 1'b1);
    check("rst_oeb2", sram_oeb2, 1'b1);
    check("rst_oeb1", sram_oeb1, 1'b1);
    check("rst_web2", sram_web2, 1'b1);
    check("rst_deq_valid", deq_valid, 1'b0);
    check("rst_count", count, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 16'h0, 1'b1);
      check("idle_deq_valid", obs_dv, 1'b0);
      check("idle_enq_ready", obs_er, 1'b1);
      check("idle_csb1", sram_csb1, 1'b1);
      check("idle_csb2", sram_csb2, 1'b1);
    end

    cyc(1'b1, 16'hA5A5, 1'b1);
    check("single_csb1", sram_csb1, BYP);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 16'h0, 1'b1);
      check("single_latency_valid", obs_dv, (k == LAT));
      if (k == LAT) check("single_data", obs_dd, 16'hA5A5);
    end

    for (int i = 0; i < 130; i++) begin
      cyc(1'b1, 16'(i), 1'b0);
      check("fill_enq_ready", obs_er, 1'b1);
    end
    cyc(1'b1, 16'hFFFF, 1'b0);
    check("full_enq_ready", obs_er, 1'b0);
    check("full_count", obs_cnt, 130);
    drain();

    deq_n = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, 16'(i * 7 + 3), 1'b1);
      check("stream_count_le3", (obs_cnt <= 8'd3), 1'b1);
    end
    check("stream_words_out", deq_n, 1000 - LAT);
    drain();

    for (int i = 0; i < 5000; i++)
      cyc($urandom_range(99) < 50, 16'($urandom), $urandom_range(99) < 30);
    drain();

    for (int i = 0; i < 51; i++) cyc(1'b1, 16'(16'h5000 + i), 1'b0);
    cyc(1'b0, 16'h0, 1'b1);
    check("pre_reset_count", count, 50);
    reset = 1'b1;
    #1;
    check("async_rst_deq_valid", deq_valid, 1'b0);
    check("async_rst_count", count, 0);
    check("async_rst_csb2", sram_csb2, 1'b1);
    q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    deq_n = 0;
    cyc(1'b1, 16'h1234, 1'b1);
    drain();
    check("post_reset_words", deq_n, 1);
    check("post_reset_first", last_deq, 16'h1234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
